// File: rtl/mm_pkg.sv
// mm_pkg: shared types and constants for the matrix-multiply tile sequencer.
// Holds the state encoding, work_mode codes and the work_mode -> pe_mode map.
package mm_pkg;

    localparam int MM_PE_ROW = 4;
    localparam int MM_PE_COL = 4;
    localparam int MM_N      = MM_PE_ROW * MM_PE_COL;
    localparam int MM_IW     = $clog2(MM_N);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_COMPUTE,
        ST_STORE,
        ST_FINISH
    } state_t;

    localparam logic [1:0] WM_ILLEGAL = 2'b00;
    localparam logic [1:0] WM_A_ONLY  = 2'b01;
    localparam logic [1:0] WM_AB      = 2'b10;
    localparam logic [1:0] WM_AB_ACC  = 2'b11;

    function automatic logic [1:0] pe_mode_map(input logic [1:0] wm);
        logic [1:0] pm;
        case (wm)
            WM_A_ONLY: pm = 2'b00;
            WM_AB:     pm = 2'b01;
            WM_AB_ACC: pm = 2'b11;
            default:   pm = 2'b00;
        endcase
        return pm;
    endfunction

endpackage

// File: rtl/mm_addr_cnt.sv
// mm_addr_cnt: paired issue/return counters with base+index address output.
// Shared by the LOAD and STORE phases; a clear takes priority over increments.
module mm_addr_cnt
    import mm_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int N      = 16,
    localparam int CW    = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_inc_iss,
    input  logic              i_inc_ret,
    input  logic [AWIDTH-1:0] i_base,
    output logic [CW-1:0]     o_iss,
    output logic [CW-1:0]     o_ret,
    output logic [AWIDTH-1:0] o_addr
);

    logic [CW-1:0] r_iss;
    logic [CW-1:0] r_ret;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_iss <= '0;
            r_ret <= '0;
        end else begin
            if (i_inc_iss) r_iss <= r_iss + CW'(1);
            if (i_inc_ret) r_ret <= r_ret + CW'(1);
        end
    end

    // Address wraps modulo 2^AWIDTH by plain truncation.
    assign o_addr = i_base + AWIDTH'(r_iss);
    assign o_iss  = r_iss;
    assign o_ret  = r_ret;

endmodule

// File: rtl/mm_tile_sched.sv
// mm_tile_sched: tile sequencer for the matrix-multiply coprocessor.
// Loads operand tiles, launches the PE array and writes the result tile back.
module mm_tile_sched
    import mm_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 16,
    parameter int PE_ROW  = MM_PE_ROW,
    parameter int PE_COL  = MM_PE_COL,
    localparam int N      = PE_ROW * PE_COL,
    localparam int IW     = $clog2(N),
    localparam int CW     = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        work_mode,
    input  logic [AWIDTH-1:0] base_a,
    input  logic [AWIDTH-1:0] base_b,
    input  logic [AWIDTH-1:0] base_c,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              buf_we,
    output logic              buf_sel,
    output logic [IW-1:0]     buf_idx,
    output logic [DWIDTH-1:0] buf_wdata,
    output logic              pe_start,
    output logic [1:0]        pe_mode,
    input  logic              pe_done,
    output logic [IW-1:0]     res_idx,
    input  logic [DWIDTH-1:0] res_rdata
);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_pe_start;
    logic              r_b_needed;
    logic [1:0]        r_pe_mode;
    logic [AWIDTH-1:0] r_base_a;
    logic [AWIDTH-1:0] r_base_b;
    logic [AWIDTH-1:0] r_base_c;

    logic              w_load;
    logic              w_store;
    logic              w_req;
    logic              w_buf_we;
    logic              w_clr;
    logic              w_ret_last;
    logic              w_iss_last;
    logic [AWIDTH-1:0] w_base;
    logic [AWIDTH-1:0] w_addr;
    logic [CW-1:0]     w_iss;
    logic [CW-1:0]     w_ret;

    assign w_load     = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    assign w_store    = (r_state == ST_STORE);
    assign w_req      = (w_load || w_store) && (w_iss < CW'(N));
    assign w_buf_we   = w_load && mem_rvalid && (w_ret < CW'(N));
    assign w_ret_last = w_buf_we && (w_ret == CW'(N - 1));
    assign w_iss_last = w_store && mem_gnt && (w_iss == CW'(N - 1));
    // Counters restart at every phase boundary that begins a new sweep.
    assign w_clr      = (r_state == ST_IDLE) || (r_state == ST_COMPUTE)
                      || w_ret_last;

    always_comb begin
        w_base = r_base_a;
        if (r_state == ST_LOAD_B) w_base = r_base_b;
        else if (r_state == ST_STORE) w_base = r_base_c;
    end

    mm_addr_cnt #(
        .AWIDTH (AWIDTH),
        .N      (N)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_inc_iss (w_req && mem_gnt),
        .i_inc_ret (w_buf_we),
        .i_base    (w_base),
        .o_iss     (w_iss),
        .o_ret     (w_ret),
        .o_addr    (w_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_pe_start <= 1'b0;
            r_b_needed <= 1'b0;
            r_pe_mode  <= 2'b00;
            r_base_a   <= '0;
            r_base_b   <= '0;
            r_base_c   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_pe_start <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start && work_mode == WM_ILLEGAL) begin
                        r_err <= 1'b1;
                    end else if (start) begin
                        r_state    <= ST_LOAD_A;
                        r_busy     <= 1'b1;
                        r_b_needed <= (work_mode != WM_A_ONLY);
                        r_pe_mode  <= pe_mode_map(work_mode);
                        r_base_a   <= base_a;
                        r_base_b   <= base_b;
                        r_base_c   <= base_c;
                    end
                end
                ST_LOAD_A: begin
                    if (w_ret_last) begin
                        if (r_b_needed) begin
                            r_state <= ST_LOAD_B;
                        end else begin
                            r_state    <= ST_COMPUTE;
                            r_pe_start <= 1'b1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (w_ret_last) begin
                        r_state    <= ST_COMPUTE;
                        r_pe_start <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    if (pe_done) r_state <= ST_STORE;
                end
                ST_STORE: begin
                    if (w_iss_last) begin
                        r_state <= ST_FINISH;
                        r_done  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign pe_start  = r_pe_start;
    assign pe_mode   = r_pe_mode;
    assign mem_req   = w_req;
    assign mem_we    = w_store;
    assign mem_addr  = w_req ? w_addr : '0;
    assign mem_wdata = w_store ? res_rdata : '0;
    assign res_idx   = w_store ? w_iss[IW-1:0] : '0;
    assign buf_we    = w_buf_we;
    assign buf_sel   = (r_state == ST_LOAD_B);
    assign buf_idx   = w_buf_we ? w_ret[IW-1:0] : '0;
    assign buf_wdata = w_buf_we ? mem_rdata : '0;

endmodule

// File: tb/tb_mm_tile_sched.sv
// tb_mm_tile_sched: directed and randomized checks of the tile sequencer
// against a transaction-level model of the expected memory/buffer traffic.
module tb_mm_tile_sched;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    work_mode;
    logic [AW-1:0] base_a, base_b, base_c;
    logic          busy, done, err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt, mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          buf_we, buf_sel;
    logic [IW-1:0] buf_idx;
    logic [DW-1:0] buf_wdata;
    logic          pe_start;
    logic [1:0]    pe_mode;
    logic          pe_done;
    logic [IW-1:0] res_idx;
    logic [DW-1:0] res_rdata;
    logic [97:0]   w_outs;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0] pm_tab [4] = '{2'b00, 2'b00, 2'b01, 2'b11};

    logic [15:0] q_rd [$];
    logic [15:0] q_wa [$];
    logic [31:0] q_wd [$];
    logic        q_bs [$];
    logic [3:0]  q_bi [$];
    logic [31:0] q_bd [$];
    int          q_pt [$];
    logic [31:0] q_pd [$];

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [15:0] a);
        return {a ^ 16'hA5A5, ~a};
    endfunction

    function automatic logic [31:0] resfn(input logic [3:0] i);
        return 32'hC0DE_0000 + 32'(i) * 32'h101;
    endfunction

    assign res_rdata = resfn(res_idx);
    assign w_outs = {busy, done, err, mem_req, mem_we, buf_we, pe_start,
                     buf_sel, pe_mode, mem_addr, mem_wdata, buf_idx,
                     res_idx, buf_wdata};

    mm_tile_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .work_mode  (work_mode),
        .base_a     (base_a),
        .base_b     (base_b),
        .base_c     (base_c),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .buf_we     (buf_we),
        .buf_sel    (buf_sel),
        .buf_idx    (buf_idx),
        .buf_wdata  (buf_wdata),
        .pe_start   (pe_start),
        .pe_mode    (pe_mode),
        .pe_done    (pe_done),
        .res_idx    (res_idx),
        .res_rdata  (res_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_tile(input logic [1:0] mode,
                            input logic [15:0] ba, input logic [15:0] bb,
                            input logic [15:0] bc, input int lat_max,
                            input int gnt_pct, input int pd_pct,
                            input bit junk, input int exp_done);
        int          done_cyc = -1;
        int          n_pe = 0;
        int          n_err = 0;
        int          n_sel1 = 0;
        int          last_rdy = -1;
        int          rdy;
        int          n_rd;
        logic [1:0]  pm_seen = 2'b00;
        bit          stall = 1'b0;
        logic [48:0] held = '0;
        logic [15:0] ea;
        q_rd.delete(); q_wa.delete(); q_wd.delete();
        q_bs.delete(); q_bi.delete(); q_bd.delete();
        q_pt.delete(); q_pd.delete();
        for (int cyc = 0; cyc < 3000 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start     = (cyc == 0) || (junk && cyc >= 2 && $urandom_range(0, 3) == 0);
            work_mode = (cyc == 0) ? mode : 2'($urandom);
            base_a    = (cyc == 0) ? ba : 16'($urandom);
            base_b    = (cyc == 0) ? bb : 16'($urandom);
            base_c    = (cyc == 0) ? bc : 16'($urandom);
            mem_gnt   = ($urandom_range(0, 99) < gnt_pct);
            if (q_pt.size() > 0 && q_pt[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = q_pd.pop_front();
                void'(q_pt.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            pe_done = ($urandom_range(0, 99) < pd_pct);
            #1;
            if (cyc == 1) begin
                chk("busy_c1", 128'(busy), 128'(1));
                chk("req_c1", 128'(mem_req), 128'(1));
            end
            if (stall)
                chk("req_hold", 128'({mem_req, mem_we, mem_addr, mem_wdata}),
                    128'({1'b1, held}));
            stall = mem_req && !mem_gnt;
            held  = {mem_we, mem_addr, mem_wdata};
            if (mem_req && mem_gnt) begin
                if (mem_we) begin
                    q_wa.push_back(mem_addr);
                    q_wd.push_back(mem_wdata);
                end else begin
                    q_rd.push_back(mem_addr);
                    rdy = cyc + int'($urandom_range(1, lat_max));
                    if (rdy <= last_rdy) rdy = last_rdy + 1;
                    last_rdy = rdy;
                    q_pt.push_back(rdy);
                    q_pd.push_back(memfn(mem_addr));
                end
            end
            if (buf_we) begin
                q_bs.push_back(buf_sel);
                q_bi.push_back(buf_idx);
                q_bd.push_back(buf_wdata);
            end
            if (buf_sel) n_sel1++;
            if (pe_start) begin
                n_pe++;
                pm_seen = pe_mode;
            end
            if (err) n_err++;
            if (done) done_cyc = cyc;
        end
        chk("done_seen", 128'(done_cyc >= 0), 128'(1));
        @(negedge clk);
        start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; pe_done = 1'b0;
        #1 chk("idle_after", 128'(busy), 128'(0));
        n_rd = (mode == 2'b01) ? N : 2 * N;
        chk("rd_count", 128'(q_rd.size()), 128'(n_rd));
        chk("buf_count", 128'(q_bs.size()), 128'(n_rd));
        chk("wr_count", 128'(q_wa.size()), 128'(N));
        for (int k = 0; k < n_rd && k < q_rd.size(); k++) begin
            ea = (k < N) ? ba + 16'(k) : bb + 16'(k - N);
            chk("rd_addr", 128'(q_rd[k]), 128'(ea));
        end
        for (int k = 0; k < n_rd && k < q_bs.size(); k++) begin
            ea = (k < N) ? ba + 16'(k) : bb + 16'(k - N);
            chk("buf_write", 128'({q_bs[k], q_bi[k], q_bd[k]}),
                128'({k >= N, 4'(k % N), memfn(ea)}));
        end
        for (int k = 0; k < N && k < q_wa.size(); k++)
            chk("mem_write", 128'({q_wa[k], q_wd[k]}),
                128'({bc + 16'(k), resfn(4'(k))}));
        chk("pe_start_cnt", 128'(n_pe), 128'(1));
        chk("pe_mode", 128'(pm_seen), 128'(pm_tab[mode]));
        chk("no_err_busy", 128'(n_err), 128'(0));
        if (mode == 2'b01) chk("no_sel_b", 128'(n_sel1), 128'(0));
        if (exp_done >= 0) chk("done_cycle", 128'(done_cyc), 128'(exp_done));
    endtask

    initial begin
        logic [1:0] m;
        int         guard;
        bit         in_b;

        rst_n = 1'b0; start = 1'b0; work_mode = 2'b00;
        base_a = '0; base_b = '0; base_c = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; pe_done = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("reset_outs", 128'(w_outs), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset_release", 128'(w_outs), '0);

        run_tile(2'b10, 16'h0100, 16'h0200, 16'h0300, 1, 100, 100, 1'b0, 52);
        run_tile(2'b01, 16'h1000, 16'h2000, 16'h3000, 1, 100, 100, 1'b0, 35);

        @(negedge clk);
        start = 1'b1; work_mode = 2'b00; mem_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("err_pulse", 128'(err), 128'(1));
        chk("err_no_busy", 128'(busy), 128'(0));
        chk("err_no_req", 128'(mem_req), 128'(0));
        @(negedge clk);
        #1 chk("err_single", 128'({err, busy, mem_req}), '0);
        mem_gnt = 1'b0;

        for (int t = 0; t < 6; t++) begin
            m = 2'($urandom_range(1, 3));
            run_tile(m, 16'($urandom), 16'($urandom), 16'($urandom),
                     4, 60, 30, 1'b1, -1);
        end

        run_tile(2'b11, 16'hFFFE, 16'hFFF8, 16'hFFF5, 4, 70, 50, 1'b1, -1);

        @(negedge clk);
        start = 1'b1; work_mode = 2'b11;
        base_a = 16'h0400; base_b = 16'h0500; base_c = 16'h0600;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom; pe_done = 1'b0;
        guard = 0;
        in_b  = 1'b0;
        while (!in_b && guard < 100) begin
            @(negedge clk);
            start = 1'b0;
            mem_rdata = $urandom;
            #1;
            in_b = buf_we && buf_sel;
            guard++;
        end
        chk("reach_load_b", 128'(in_b), 128'(1));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1 chk("midrst_outs", 128'(w_outs), '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata = $urandom;
            #1 chk("stale_rvalid", 128'(w_outs), '0);
        end
        mem_rvalid = 1'b0;
        mem_gnt = 1'b0;

        run_tile(2'b11, 16'h0700, 16'h0800, 16'h0900, 1, 100, 100, 1'b0, 52);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
